// File: rtl/ip_filter_table_ctrl.sv
// ip_filter_table_ctrl
// Converts host register-bus accesses into request/ack transactions on the
// IP-filter table port. The host sees five indirect registers:
//   0 ADDR     table address, bits[TABLE_AW-1:0] R/W
//   1 WR_DATA  entry to write, R/W
//   2 RD_DATA  entry captured by the last successful read, read-only
//   3 CMD      write-only: bit0 = read, bit1 = write (exactly one must be set)
//   4 STATUS   bit0 busy, bit1 done, bit2 timeout, bit3 cmd_error
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   reg_req/rd_wr_L/... host register bus; reg_ack pulses one cycle after
//                       reg_req, with reg_rd_data valid alongside it
//   table_rd_*          read request/ack handshake toward the table
//   table_wr_*          write request/ack handshake toward the table
// Each table request is bounded: after TIMEOUT_CYCLES cycles without an ack
// it is abandoned and STATUS.timeout is raised.
// DATA_W must not exceed the 32-bit host data bus.
module ip_filter_table_ctrl #(
  parameter int TABLE_AW       = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_req,
  input  logic                reg_rd_wr_L,
  input  logic [2:0]          reg_addr,
  input  logic [31:0]         reg_wr_data,
  output logic                reg_ack,
  output logic [31:0]         reg_rd_data,
  output logic                table_rd_req,
  input  logic                table_rd_ack,
  output logic [TABLE_AW-1:0] table_rd_addr,
  input  logic [DATA_W-1:0]   table_rd_data,
  output logic                table_wr_req,
  input  logic                table_wr_ack,
  output logic [TABLE_AW-1:0] table_wr_addr,
  output logic [DATA_W-1:0]   table_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_RD_REQ = 3'b010,
    S_WR_REQ = 3'b100
  } state_e;

  localparam logic [2:0] OFF_ADDR    = 3'd0;
  localparam logic [2:0] OFF_WR_DATA = 3'd1;
  localparam logic [2:0] OFF_RD_DATA = 3'd2;
  localparam logic [2:0] OFF_CMD     = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;

  // Counter value seen in the last allowed wait cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [TABLE_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  cmd_error_q, cmd_error_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  reg_ack_q, reg_ack_d;
  logic [31:0]           reg_rd_data_q, reg_rd_data_d;
  logic                  table_rd_req_q, table_rd_req_d;
  logic                  table_wr_req_q, table_wr_req_d;
  logic [TABLE_AW-1:0]   table_rd_addr_q, table_rd_addr_d;
  logic [TABLE_AW-1:0]   table_wr_addr_q, table_wr_addr_d;
  logic [DATA_W-1:0]     table_wr_data_q, table_wr_data_d;

  logic reg_wr;
  logic reg_rd;

  assign reg_wr = reg_req && !reg_rd_wr_L;
  assign reg_rd = reg_req &&  reg_rd_wr_L;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // branches below leaves one unassigned, which would infer a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    wr_data_d       = wr_data_q;
    rd_data_d       = rd_data_q;
    busy_d          = busy_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    cmd_error_d     = cmd_error_q;
    cnt_d           = cnt_q;
    table_rd_req_d  = table_rd_req_q;
    table_wr_req_d  = table_wr_req_q;
    table_rd_addr_d = table_rd_addr_q;
    table_wr_addr_d = table_wr_addr_q;
    table_wr_data_d = table_wr_data_q;
    reg_ack_d       = reg_req;
    reg_rd_data_d   = '0;

    // Host reads return the register contents as they stand before this edge.
    if (reg_rd) begin
      case (reg_addr)
        OFF_ADDR:    reg_rd_data_d = 32'(addr_q);
        OFF_WR_DATA: reg_rd_data_d = 32'(wr_data_q);
        OFF_RD_DATA: reg_rd_data_d = 32'(rd_data_q);
        OFF_STATUS:  reg_rd_data_d = {28'd0, cmd_error_q, timeout_q, done_q, busy_q};
        default:     reg_rd_data_d = '0;
      endcase
    end

    if (reg_wr) begin
      case (reg_addr)
        OFF_ADDR:    addr_d    = reg_wr_data[TABLE_AW-1:0];
        OFF_WR_DATA: wr_data_d = reg_wr_data[DATA_W-1:0];
        OFF_CMD: begin
          if (state_q != S_IDLE) begin
            // A second command never disturbs the transaction in flight.
            cmd_error_d = 1'b1;
          end else if (reg_wr_data[1:0] == 2'b01 || reg_wr_data[1:0] == 2'b10) begin
            busy_d      = 1'b1;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
            cmd_error_d = 1'b0;
            cnt_d       = '0;
            // Address and data are frozen here so later host writes to
            // ADDR/WR_DATA cannot alter the active transaction.
            if (reg_wr_data[0]) begin
              state_d         = S_RD_REQ;
              table_rd_req_d  = 1'b1;
              table_rd_addr_d = addr_q;
            end else begin
              state_d         = S_WR_REQ;
              table_wr_req_d  = 1'b1;
              table_wr_addr_d = addr_q;
              table_wr_data_d = wr_data_q;
            end
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // The ack is checked before the timeout so an ack in the final allowed
    // cycle still completes the transaction.
    case (state_q)
      S_RD_REQ: begin
        if (table_rd_ack) begin
          rd_data_d      = table_rd_data;
          table_rd_req_d = 1'b0;
          done_d         = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          table_rd_req_d = 1'b0;
          timeout_d      = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WR_REQ: begin
        if (table_wr_ack) begin
          table_wr_req_d = 1'b0;
          done_d         = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          table_wr_req_d = 1'b0;
          timeout_d      = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its input from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      wr_data_q       <= '0;
      rd_data_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      cmd_error_q     <= 1'b0;
      cnt_q           <= '0;
      reg_ack_q       <= 1'b0;
      reg_rd_data_q   <= '0;
      table_rd_req_q  <= 1'b0;
      table_wr_req_q  <= 1'b0;
      table_rd_addr_q <= '0;
      table_wr_addr_q <= '0;
      table_wr_data_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      rd_data_q       <= rd_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      cmd_error_q     <= cmd_error_d;
      cnt_q           <= cnt_d;
      reg_ack_q       <= reg_ack_d;
      reg_rd_data_q   <= reg_rd_data_d;
      table_rd_req_q  <= table_rd_req_d;
      table_wr_req_q  <= table_wr_req_d;
      table_rd_addr_q <= table_rd_addr_d;
      table_wr_addr_q <= table_wr_addr_d;
      table_wr_data_q <= table_wr_data_d;
    end
  end

  assign reg_ack       = reg_ack_q;
  assign reg_rd_data   = reg_rd_data_q;
  assign table_rd_req  = table_rd_req_q;
  assign table_rd_addr = table_rd_addr_q;
  assign table_wr_req  = table_wr_req_q;
  assign table_wr_addr = table_wr_addr_q;
  assign table_wr_data = table_wr_data_q;

endmodule

// File: tb/tb_ip_filter_table_ctrl.sv
// Directed bench for ip_filter_table_ctrl: drives the host register bus and
// plays the table responder by hand, one step at a time.
module tb_ip_filter_table_ctrl;

  localparam logic [2:0] A_ADDR = 3'd0, A_WRD = 3'd1, A_RDD = 3'd2,
                         A_CMD = 3'd3, A_STAT = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_req;
  logic        reg_rd_wr_L;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_ack;
  logic [31:0] reg_rd_data;
  logic        table_rd_req;
  logic        table_rd_ack;
  logic [4:0]  table_rd_addr;
  logic [31:0] table_rd_data;
  logic        table_wr_req;
  logic        table_wr_ack;
  logic [4:0]  table_wr_addr;
  logic [31:0] table_wr_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_rises = 0;
  logic wr_req_prev = 1'b0;

  always #5 clk = ~clk;

  ip_filter_table_ctrl #(
    .TABLE_AW(5), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
    .table_rd_req(table_rd_req), .table_rd_ack(table_rd_ack),
    .table_rd_addr(table_rd_addr), .table_rd_data(table_rd_data),
    .table_wr_req(table_wr_req), .table_wr_ack(table_wr_ack),
    .table_wr_addr(table_wr_addr), .table_wr_data(table_wr_data)
  );

  // Counts write transactions started (rising edges of table_wr_req).
  always @(posedge clk) begin
    wr_req_prev <= table_wr_req;
    if (table_wr_req && !wr_req_prev) wr_rises <= wr_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    reg_req = 1'b1; reg_rd_wr_L = 1'b0; reg_addr = a; reg_wr_data = d;
    tick();
    reg_req = 1'b0; reg_wr_data = '0;
  endtask

  task automatic reg_rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = a;
    tick();
    reg_req = 1'b0;
    check({tag, "_ack"}, {31'd0, reg_ack}, 32'd1);
    check(tag, reg_rd_data, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int r0;
    reset = 1'b1; reg_req = 1'b0; reg_rd_wr_L = 1'b0; reg_addr = '0;
    reg_wr_data = '0; table_rd_ack = 1'b0; table_rd_data = '0; table_wr_ack = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_reg_ack", {31'd0, reg_ack}, 32'd0);
    check("rst_reg_rd_data", reg_rd_data, 32'd0);
    check("rst_rd_req", {31'd0, table_rd_req}, 32'd0);
    check("rst_wr_req", {31'd0, table_wr_req}, 32'd0);
    check("rst_wr_addr", {27'd0, table_wr_addr}, 32'd0);
    check("rst_wr_data", table_wr_data, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_stat", {31'd0, reg_ack}, 32'd0);

    // Invalid commands: both bits, then neither bit
    reg_wr(A_CMD, 32'h3);
    check("cmd3_rd_req", {31'd0, table_rd_req}, 32'd0);
    check("cmd3_wr_req", {31'd0, table_wr_req}, 32'd0);
    reg_rd_check("cmd3_status", A_STAT, 32'h8);
    reg_wr(A_CMD, 32'h0);
    reg_rd_check("cmd0_status", A_STAT, 32'h8);
    reg_rd_check("cmd_reads0", A_CMD, 32'h0);
    reg_rd_check("off6_reads0", 3'd6, 32'h0);

    // ADDR upper bits read as 0
    reg_wr(A_ADDR, 32'hFFFF_FFE3);
    reg_rd_check("addr_mask", A_ADDR, 32'h3);

    // Read with immediate ack; valid command clears cmd_error
    reg_wr(A_CMD, 32'h1);
    check("rd_req_up", {31'd0, table_rd_req}, 32'd1);
    check("rd_addr", {27'd0, table_rd_addr}, 32'd3);
    check("cmd_ack", {31'd0, reg_ack}, 32'd1);
    table_rd_ack = 1'b1; table_rd_data = 32'hC0A8_0001;
    tick();
    table_rd_ack = 1'b0; table_rd_data = '0;
    check("rd_req_drop", {31'd0, table_rd_req}, 32'd0);
    reg_rd_check("rd_rddata", A_RDD, 32'hC0A8_0001);
    reg_rd_check("rd_status", A_STAT, 32'h2);

    // Write, responder acks one cycle after req
    reg_wr(A_WRD, 32'h0A00_0001);
    reg_rd_check("wrdata_rb", A_WRD, 32'h0A00_0001);
    reg_wr(A_CMD, 32'h2);
    check("wr_req_c1", {31'd0, table_wr_req}, 32'd1);
    check("wr_addr", {27'd0, table_wr_addr}, 32'd3);
    check("wr_data", table_wr_data, 32'h0A00_0001);
    tick();
    check("wr_req_c2", {31'd0, table_wr_req}, 32'd1);
    table_wr_ack = 1'b1;
    tick();
    table_wr_ack = 1'b0;
    check("wr_req_c3", {31'd0, table_wr_req}, 32'd0);
    reg_rd_check("wr_status", A_STAT, 32'h2);
    reg_wr(A_RDD, 32'hFFFF_FFFF);
    reg_rd_check("rddata_ro", A_RDD, 32'hC0A8_0001);

    // Read timeout; a write ack held throughout must be ignored
    reg_wr(A_CMD, 32'h1);
    table_wr_ack = 1'b1;
    n = 0;
    while (table_rd_req && n < 40) begin
      n++;
      tick();
    end
    table_wr_ack = 1'b0;
    check("to_len", n, 32'd16);
    reg_rd_check("to_status", A_STAT, 32'h4);
    reg_rd_check("to_rddata", A_RDD, 32'hC0A8_0001);

    // Ack in the last allowed cycle beats the timeout
    reg_wr(A_CMD, 32'h1);
    repeat (15) tick();
    check("last_rd_req", {31'd0, table_rd_req}, 32'd1);
    table_rd_ack = 1'b1; table_rd_data = 32'h55AA_0001;
    tick();
    table_rd_ack = 1'b0; table_rd_data = '0;
    check("last_drop", {31'd0, table_rd_req}, 32'd0);
    reg_rd_check("last_status", A_STAT, 32'h2);
    reg_rd_check("last_rddata", A_RDD, 32'h55AA_0001);

    // CMD and ADDR writes while busy
    reg_wr(A_ADDR, 32'd5);
    reg_wr(A_WRD, 32'h1234_5678);
    r0 = wr_rises;
    reg_wr(A_CMD, 32'h2);
    reg_wr(A_CMD, 32'h2);
    reg_wr(A_ADDR, 32'd9);
    check("busy_wr_req", {31'd0, table_wr_req}, 32'd1);
    check("busy_wr_addr", {27'd0, table_wr_addr}, 32'd5);
    check("busy_wr_data", table_wr_data, 32'h1234_5678);
    tick(); tick();
    table_wr_ack = 1'b1;
    tick();
    table_wr_ack = 1'b0;
    check("busy_drop", {31'd0, table_wr_req}, 32'd0);
    tick(); tick();
    check("busy_one_txn", wr_rises - r0, 32'd1);
    reg_rd_check("busy_status", A_STAT, 32'hA);
    reg_rd_check("busy_addr", A_ADDR, 32'd9);

    // Ack while idle is ignored
    table_rd_ack = 1'b1; table_rd_data = 32'hDEAD_BEEF;
    tick();
    table_rd_ack = 1'b0; table_rd_data = '0;
    reg_rd_check("idle_ack_rddata", A_RDD, 32'h55AA_0001);
    reg_rd_check("idle_ack_status", A_STAT, 32'hA);

    // Reset in the middle of a write, with a register read pending
    reg_wr(A_CMD, 32'h2);
    check("mid_wr_req", {31'd0, table_wr_req}, 32'd1);
    reset = 1'b1; reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = A_STAT;
    tick();
    reg_req = 1'b0;
    check("mid_req_drop", {31'd0, table_wr_req}, 32'd0);
    check("mid_no_ack", {31'd0, reg_ack}, 32'd0);
    check("mid_wr_addr", {27'd0, table_wr_addr}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_no_ack2", {31'd0, reg_ack}, 32'd0);
    reg_rd_check("mid_addr", A_ADDR, 32'd0);
    reg_rd_check("mid_wrdata", A_WRD, 32'd0);
    reg_rd_check("mid_rddata", A_RDD, 32'd0);
    reg_rd_check("mid_status", A_STAT, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
